// File: rtl/ltc2324_axis_packer.sv
// Buffers 4x16-bit LTC2324 samples in a small FIFO and streams each one as two 32-bit AXIS beats,
// with TLAST closing every PKT_SAMPLES-sample packet and a sticky overflow / drop counter.
module ltc2324_axis_packer #(
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned PKT_SAMPLES = 256,
  parameter int unsigned DROP_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          sample_valid,
  input  logic [15:0]                   ch1,
  input  logic [15:0]                   ch2,
  input  logic [15:0]                   ch3,
  input  logic [15:0]                   ch4,
  output logic [31:0]                   m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic                          capturing,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic [DROP_W-1:0]             drop_cnt
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = (PKT_SAMPLES > 1) ? $clog2(PKT_SAMPLES) : 1;
  localparam logic [CW-1:0] CntMax = CW'(PKT_SAMPLES - 1);
  localparam logic [AW:0]   Depth  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StBeat0, StBeat1} state_e;

  state_e            state_q, state_d;
  logic [63:0]       mem_q [FIFO_DEPTH];
  logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_ptr_nx, level;
  logic [CW-1:0]     in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
  logic              capturing_q, capturing_d;
  logic              overflow_q, overflow_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [31:0]       tdata_q, tdata_d;
  logic              tvalid_q, tvalid_d, tlast_q, tlast_d;
  logic              full, empty, accept, wr_en, drop, pop;
  logic [63:0]       head, head_nx;

  // Pointers carry one extra wrap bit so level distinguishes full from empty.
  assign level     = wr_ptr_q - rd_ptr_q;
  assign full      = (level == Depth);
  assign empty     = (level == '0);
  assign accept    = sample_valid && capturing_q;
  assign wr_en     = accept && !full;
  assign drop      = accept && full;
  assign rd_ptr_nx = rd_ptr_q + (AW + 1)'(1);
  assign head      = mem_q[rd_ptr_q[AW-1:0]];
  assign head_nx   = mem_q[rd_ptr_nx[AW-1:0]];

  always_comb begin
    in_cnt_d   = in_cnt_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (accept) begin
      in_cnt_d = (in_cnt_q == CntMax) ? '0 : in_cnt_q + CW'(1);
    end
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + DROP_W'(1);
    end
    // Gate only changes at packet boundaries, so a closing packet always completes.
    capturing_d = capturing_q ? (enable || (in_cnt_d != '0)) : (enable && (in_cnt_q == '0));
  end

  always_comb begin
    state_d   = state_q;
    tdata_d   = tdata_q;
    tvalid_d  = tvalid_q;
    tlast_d   = tlast_q;
    out_cnt_d = out_cnt_q;
    pop       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          tdata_d  = head[31:0];
          tvalid_d = 1'b1;
          tlast_d  = 1'b0;
          state_d  = StBeat0;
        end
      end
      StBeat0: begin
        if (m_axis_tready) begin
          tdata_d = head[63:32];
          tlast_d = (out_cnt_q == CntMax);
          state_d = StBeat1;
        end
      end
      StBeat1: begin
        if (m_axis_tready) begin
          pop       = 1'b1;
          out_cnt_d = (out_cnt_q == CntMax) ? '0 : out_cnt_q + CW'(1);
          tlast_d   = 1'b0;
          if (level > (AW + 1)'(1)) begin
            tdata_d = head_nx[31:0];
            state_d = StBeat0;
          end else begin
            tvalid_d = 1'b0;
            state_d  = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    rd_ptr_d = rd_ptr_q + (AW + 1)'(pop);
    wr_ptr_d = wr_ptr_q + (AW + 1)'(wr_en);
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= {ch4, ch3, ch2, ch1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      capturing_q <= 1'b0;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= '0;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      capturing_q <= capturing_d;
      overflow_q  <= overflow_d;
      drop_cnt_q  <= drop_cnt_d;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign capturing     = capturing_q;
  assign fifo_level    = level;
  assign overflow      = overflow_q;
  assign drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_ltc2324_axis_packer.sv
// Randomised and directed bench for ltc2324_axis_packer against a queue-based packet model.
module tb_ltc2324_axis_packer;

  localparam int unsigned Depth = 4;
  localparam int unsigned Pkt   = 4;
  localparam int unsigned DropW = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0, sample_valid = 1'b0, m_axis_tready = 1'b0;
  logic [15:0] ch1 = '0, ch2 = '0, ch3 = '0, ch4 = '0;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tlast, capturing, overflow;
  logic [$clog2(Depth):0] fifo_level;
  logic [DropW-1:0]       drop_cnt;

  ltc2324_axis_packer #(.FIFO_DEPTH(Depth), .PKT_SAMPLES(Pkt), .DROP_W(DropW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sample_valid(sample_valid),
    .ch1(ch1), .ch2(ch2), .ch3(ch3), .ch4(ch4),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .capturing(capturing), .fifo_level(fifo_level), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: expected beats in output order as {tlast, tdata}.
  logic [32:0] beatq[$];
  int  level_m, acc_m, in_m, drop_m, stall;
  bit  cap_m, ovf_m, second_m, hold_m;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    beatq.delete();
    level_m = 0; acc_m = 0; in_m = 0; drop_m = 0; stall = 0;
    cap_m = 0; ovf_m = 0; second_m = 0; hold_m = 0;
  endtask

  task automatic model_edge();
    bit hs;
    int lvl_pre, in_old;
    logic [63:0] s;
    logic [32:0] b;
    hs      = m_axis_tvalid && m_axis_tready;
    hold_m  = m_axis_tvalid && !m_axis_tready;
    lvl_pre = level_m;
    in_old  = in_m;
    s       = {ch4, ch3, ch2, ch1};
    if (hs && beatq.size() > 0) begin
      b = beatq.pop_front();
      if (second_m) level_m--;
      second_m = !second_m;
    end
    if (cap_m && sample_valid) begin
      if (lvl_pre == Depth) begin
        ovf_m = 1;
        if (drop_m != 65535) drop_m++;
      end else begin
        beatq.push_back({1'b0, s[31:0]});
        beatq.push_back({(acc_m == Pkt - 1) ? 1'b1 : 1'b0, s[63:32]});
        acc_m = (acc_m + 1) % Pkt;
        level_m++;
      end
      in_m = (in_m + 1) % Pkt;
    end
    cap_m = cap_m ? (enable || in_m != 0) : (enable && in_old == 0);
  endtask

  task automatic check_outputs();
    logic [32:0] b;
    chk("capturing", capturing, cap_m);
    chk("fifo_level", fifo_level, level_m);
    chk("overflow", overflow, ovf_m);
    chk("drop_cnt", drop_cnt, drop_m);
    chk("tvalid_hold", hold_m && !m_axis_tvalid, 0);
    if (m_axis_tvalid) begin
      if (beatq.size() == 0) begin
        chk("spurious_beat", 1, 0);
      end else begin
        b = beatq[0];
        chk("tdata", m_axis_tdata, b[31:0]);
        chk("tlast", m_axis_tlast, b[32]);
      end
    end
    if (!m_axis_tvalid && level_m > 0) stall++;
    else stall = 0;
    chk("no_stall", stall > 1, 0);
  endtask

  // One clock: drive at the falling edge, let the rising edge act, check at the next falling edge.
  task automatic step(input bit en, input bit sv, input logic [63:0] s, input bit rdy);
    enable = en; sample_valid = sv; m_axis_tready = rdy;
    {ch4, ch3, ch2, ch1} = s;
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    enable = 0; sample_valid = 0; m_axis_tready = 0;
    #1;
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_capturing", capturing, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_drop", drop_cnt, 0);
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain(input bit en);
    for (int i = 0; i < 64 && beatq.size() > 0; i++) step(en, 0, 64'h0, 1);
    chk("drain_empty", beatq.size(), 0);
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  logic [31:0] saved;

  initial begin
    model_clear();
    @(negedge clk);
    do_reset();

    // Single sample latency and beat order.
    step(1, 0, 64'h0, 1);
    step(1, 1, 64'h4444_3333_2222_1111, 1);
    chk("lat_t1_tvalid", m_axis_tvalid, 0);
    step(1, 0, 64'h0, 1);
    chk("lat_t2_tvalid", m_axis_tvalid, 1);
    chk("lat_beat0", m_axis_tdata, 32'h2222_1111);
    step(1, 0, 64'h0, 1);
    chk("lat_beat1", m_axis_tdata, 32'h4444_3333);
    chk("lat_beat1_tlast", m_axis_tlast, 0);
    step(1, 0, 64'h0, 1);
    chk("single_done", m_axis_tvalid, 0);

    // Two full packets, ch1 carries the sample index.
    do_reset();
    step(1, 0, 64'h0, 1);
    for (int k = 0; k < 8; k++) begin
      step(1, 1, {16'h0d0d, 16'h0c0c, 16'hbbbb, 16'(k)}, 1);
      step(1, 0, 64'h0, 1);
      step(1, 0, 64'h0, 1);
    end
    drain(1);

    // Backpressure held during BEAT0.
    step(1, 1, 64'h1234_5678_9abc_def0, 0);
    step(1, 0, 64'h0, 0);
    saved = m_axis_tdata;
    for (int k = 0; k < 20; k++) step(1, 0, 64'h0, 0);
    chk("bp_tvalid", m_axis_tvalid, 1);
    chk("bp_stable", m_axis_tdata, saved);
    drain(1);

    // Overflow: six samples into a four-deep FIFO with the sink stalled.
    do_reset();
    step(1, 0, 64'h0, 0);
    for (int k = 0; k < 6; k++) begin
      step(1, 1, {48'h0, 16'(k + 16'h100)}, 0);
      step(1, 0, 64'h0, 0);
    end
    chk("ovf_level", fifo_level, 4);
    chk("ovf_flag", overflow, 1);
    chk("ovf_drop", drop_cnt, 2);
    drain(1);

    // Enable lowered mid-packet: the packet still completes, then the gate closes.
    do_reset();
    step(1, 0, 64'h0, 1);
    for (int k = 0; k < 4; k++) begin
      step(k < 2, 1, rnd64(), 1);
      step(k < 1, 0, 64'h0, 1);
    end
    chk("en_drop_closed", capturing, 0);
    step(0, 1, rnd64(), 1);
    drain(0);
    chk("en_drop_ignored", fifo_level, 0);

    // Asynchronous reset while BEAT1 is on the bus.
    do_reset();
    step(1, 0, 64'h0, 0);
    step(1, 1, rnd64(), 0);
    for (int k = 0; k < 4 && !m_axis_tvalid; k++) step(1, 0, 64'h0, 0);
    step(1, 0, 64'h0, 1);
    chk("mid_rst_in_beat1", m_axis_tvalid && second_m, 1);
    do_reset();
    step(1, 0, 64'h0, 1);
    for (int k = 0; k < Pkt; k++) begin
      step(1, 1, rnd64(), 1);
      step(1, 0, 64'h0, 1);
    end
    drain(1);

    // Random traffic with periodic sink stalls to provoke overflow.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      step(($urandom % 8) != 0, ($urandom % 4) == 0, rnd64(),
           ((c / 60) % 4 == 3) ? 1'b0 : (($urandom % 3) != 0));
    end
    drain(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ltc2324_axis_packer.md
Name: ltc2324_axis_packer

Overview:
- Downstream stage of the LTC2324-16 4-channel sampler.
- Captures each one-cycle sample_valid pulse with its four 16-bit channel words into a small sample FIFO.
- Serialises each stored sample as two 32-bit AXI4-Stream beats toward the AXIS DMA.
- Asserts TLAST on the final beat of every PKT_SAMPLES-sample packet.
- Reports FIFO overflow so that dropped samples are visible to software.

Parameters:
FIFO_DEPTH, 16, sample entries in the FIFO (64 bits each); must be a power of 2 and at least 2
PKT_SAMPLES, 256, samples per DMA packet (2*PKT_SAMPLES beats); must be at least 1
DROP_W, 16, width of the saturating drop counter

Ports:
clk  in  1  system clock (same domain as sampler)
rst_n  in  1  asynchronous active-low reset
enable  in  1  capture request, level
sample_valid  in  1  one-cycle pulse: ch1..ch4 valid this cycle
ch1  in  16  channel 1 sample
ch2  in  16  channel 2 sample
ch3  in  16  channel 3 sample
ch4  in  16  channel 4 sample
m_axis_tdata  out  32  stream data
m_axis_tvalid  out  1  stream valid
m_axis_tready  in  1  stream ready
m_axis_tlast  out  1  end of packet
capturing  out  1  capture gate is open
fifo_level  out  $clog2(FIFO_DEPTH)+1  stored samples
overflow  out  1  sticky: at least one sample dropped since reset
drop_cnt  out  DROP_W  dropped-sample count, saturating at all-ones

Behaviour:
- Reset (async, rst_n=0) clears the following; in-flight data is discarded with no TLAST completion:
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0
  - capturing=0, fifo_level=0, overflow=0, drop_cnt=0
  - FIFO pointers, in_cnt, out_cnt, FSM=S_IDLE
- Capture gate:
  - capturing opens on the first clock where enable=1 and in_cnt==0.
  - It closes only when enable=0 and in_cnt==0, i.e. only at packet boundaries.
  - Lowering enable mid-packet therefore still completes the current packet.
- Input side, sample_valid=1 with capturing=1:
  - FIFO not full: write {ch4,ch3,ch2,ch1} at that edge.
  - FIFO full: drop the sample, set overflow, increment drop_cnt (saturating).
  - In both cases in_cnt advances modulo PKT_SAMPLES, so packets stay sample-aligned; dropped samples are absent from the packet, not padded.
  - sample_valid while capturing=0 is ignored: no write, no count, no drop.
- Full-flag rule: a write to a full FIFO is refused even if a pop occurs in the same cycle. A simultaneous write and pop on a non-full FIFO leaves fifo_level unchanged.
- Output FSM, all outputs registered:
  - S_IDLE: if FIFO not empty, load tdata={ch2,ch1} of the head entry, tvalid=1, go to S_BEAT0.
  - S_BEAT0: hold tdata/tvalid while tready=0. On handshake, load {ch4,ch3}, set tlast=(out_cnt==PKT_SAMPLES-1), go to S_BEAT1.
  - S_BEAT1: hold while tready=0. On handshake, pop the head and advance out_cnt modulo PKT_SAMPLES. Then:
    - if the FIFO still holds another entry (after the pop), load its {ch2,ch1}, tlast=0, go to S_BEAT0 with no bubble;
    - else tvalid=0, tlast=0, go to S_IDLE.
- AXIS rules: tvalid never drops without a handshake, and tdata/tlast are stable while tvalid=1 and tready=0. tlast is 0 on every BEAT0.
- Latency: sample_valid in cycle t, FIFO empty, FSM idle → m_axis_tvalid=1 in cycle t+2.
- Throughput: 1 beat/clk with tready held high, i.e. 2 clk per sample, well above the sampler rate of 1 sample per 55 clk.
- Counter widths: $clog2(PKT_SAMPLES) bits, minimum 1. With PKT_SAMPLES=1, every BEAT1 carries tlast.

Test Plan:
- Single sample: reset, enable=1, one pulse with ch1..ch4=0x1111/0x2222/0x3333/0x4444, tready=1 → beats 0x22221111 (t+2), 0x44443333 (t+3), tlast=0, then tvalid=0.
- Full packet: PKT_SAMPLES=4, 8 pulses, ch1 = sample index → tlast only on beats 8 and 16; each first beat's low half equals its index.
- Backpressure: tready=0 for 20 clk during BEAT0 → tdata/tvalid/tlast stable throughout; beats resume in order when tready returns to 1.
- Overflow: FIFO_DEPTH=4, tready=0, 6 pulses → fifo_level=4, overflow=1, drop_cnt=2. After release, exactly 4 samples stream out, the first four sent.
- Enable drop mid-packet: PKT_SAMPLES=4, enable=0 after 2 samples, 2 more pulses → both accepted, tlast on beat 8, capturing=0. A subsequent pulse is ignored.
- Reset mid-packet: assert rst_n=0 during S_BEAT1 with tvalid=1 → all outputs clear asynchronously. After re-enable, the next packet starts at out_cnt=0 and its tlast falls at beat 2*PKT_SAMPLES.
